sp_ram_bank_ctrl: RTL and testbench
===================================

Name: sp_ram_bank_ctrl

Overview:
Sits directly upstream of the 32 KB single-port SRAM bank (13-bit word address, 32-bit data, active-low byte write enables, one-cycle read latency). It converts the core-side req/gnt/rvalid memory protocol into per-cycle SRAM macro controls. It also runs a post-reset zero-initialisation sweep of the whole bank, and holds read data stable after the macro output changes.

Parameters:
ADDR_W, 13, SRAM word-address width
DEPTH, 2**ADDR_W, words in bank (8192)
INIT_EN, 1, 1 = sweep-write INIT_VALUE to every word after reset; 0 = go straight to RUN
INIT_VALUE, 32'h0000_0000, data written during sweep

Ports:
CK  in  1  clock
RST  in  1  reset, asynchronous, active-high
req_i  in  1  core request
we_i  in  1  1 = write, 0 = read
be_i  in  4  byte enables, active-high
addr_i  in  32  byte address; word index = addr_i[ADDR_W+1:2], other bits ignored
wdata_i  in  32  write data
gnt_o  out  1  request accepted this cycle
rvalid_o  out  1  response valid
rdata_o  out  32  read data
init_done_o  out  1  sweep finished, bank usable
A_o  out  ADDR_W  to SRAM A
DI_o  out  32  to SRAM DI
WEB_o  out  4  to SRAM WEB, active-low
DO_i  in  32  from SRAM DO

Behaviour:
- Clock and reset: one clock, CK. RST is asynchronous and active-high.
- Reset values:
  - state = INIT if INIT_EN else RUN; cnt = 0.
  - rvalid_o = 0; rd_pend = 0; rdata hold register = 0, so rdata_o = 0.
  - init_done_o = 0 if INIT_EN else 1.
- WEB_o while RST is high: forced combinationally to 4'hF, so no write reaches the macro during reset.
- INIT state:
  - Each cycle drives A_o = cnt, DI_o = INIT_VALUE, WEB_o = 4'h0; cnt increments.
  - When cnt == DEPTH-1, the next state is RUN and init_done_o is registered to 1 at that same edge.
  - Exactly DEPTH write cycles: first write on the first CK edge after RST falls; init_done_o rises DEPTH edges after RST falls.
  - gnt_o = 0 throughout INIT. Requests are held off, not dropped; the requester keeps req_i high.
- RUN state:
  - gnt_o = req_i, combinational. Acceptance = req_i & gnt_o.
  - A_o = addr_i[ADDR_W+1:2]; DI_o = wdata_i.
  - WEB_o = ~be_i when accepted with we_i = 1; otherwise 4'hF (idle or read).
  - be_i = 0 on a write: still granted and rvalid returned; no byte is modified.
- Response:
  - rvalid_o is registered, high exactly one cycle after every accepted request, read or write.
  - Full throughput: back-to-back requests every cycle give back-to-back rvalid_o.
  - rd_pend is registered, set when an accepted request is a read.
  - rdata_o = rd_pend ? DO_i : hold. On cycles with rd_pend = 1, hold <= DO_i.
  - rdata_o therefore keeps the last read value through write responses and idle cycles, even though the macro DO changes.
- Read-after-write to the same word in consecutive cycles returns the newly written bytes; this follows from the macro's write-then-read ordering across cycles, with no forwarding logic.
- RST asserted mid-sweep or mid-transfer:
  - Immediately: rvalid_o = 0 and gnt_o = 0. WEB_o = 4'hF while RST is high.
  - After RST falls: the sweep restarts from word 0. Any outstanding response is discarded.
- INIT_EN = 0: no sweep; gnt_o follows req_i from the first cycle after reset.

Test Plan:
- Reset release with INIT_EN = 1, DEPTH = 8192: WEB_o = 4'h0 for exactly 8192 cycles with A_o running 0..8191; init_done_o rises at edge 8192; a req_i held high from cycle 0 sees gnt_o = 0 until then, then gnt_o = 1.
- Write addr_i = 32'h0000_0010, wdata_i = 32'hDEAD_BEEF, be_i = 4'hF, then read the same address: A_o = 4, WEB_o = 4'h0, then rvalid_o on the read response with rdata_o = 32'hDEAD_BEEF.
- Byte write be_i = 4'b0100, wdata_i = 32'h00AA_0000 to a word holding 32'h1122_3344: WEB_o = 4'b1011; a subsequent read returns 32'h11AA_3344.
- Read word 5 (value 32'h5555_5555), then write word 6, then idle 3 cycles: rvalid_o high on both response cycles; rdata_o stays 32'h5555_5555 throughout while DO_i changes.
- Four back-to-back reads of words 0..3, preloaded 1, 2, 3, 4: gnt_o high all four cycles; rvalid_o high four consecutive cycles; rdata_o = 1, 2, 3, 4.
- RST pulsed at sweep cycle 100, and again one cycle after an accepted read: WEB_o = 4'hF and rvalid_o = 0 during RST; afterwards the sweep restarts at A_o = 0 and no stale rvalid_o appears.

Source files
------------

// File: rtl/sp_ram_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_bank_ctrl_if
// Description : Core-side req/gnt/rvalid memory bus for the SRAM bank controller.
// Revision    : 1.0
// ============================================================================
interface sp_ram_bank_ctrl_if;
   logic        req_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        gnt_o;
   logic        rvalid_o;
   logic [31:0] rdata_o;

   modport master (
      output req_i, we_i, be_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o
   );

   modport slave (
      input  req_i, we_i, be_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o
   );
endinterface
`default_nettype wire

// File: rtl/sp_ram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_bank_ctrl
// Description : Core bus to single-port SRAM macro controller with post-reset
//               sweep initialisation and read-data hold.
// Revision    : 1.0
// ============================================================================
module sp_ram_bank_ctrl #(
   parameter int          ADDR_W     = 13,
   parameter int          DEPTH      = 2**ADDR_W,
   parameter bit          INIT_EN    = 1'b1,
   parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
   input  wire logic              CK,
   input  wire logic              RST,
   sp_ram_bank_ctrl_if.slave      bus,
   output logic                   init_done_o,
   output logic [ADDR_W-1:0]      A_o,
   output logic [31:0]            DI_o,
   output logic [3:0]             WEB_o,
   input  wire logic [31:0]       DO_i
);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                init_done_q, init_done_d;
   logic                rvalid_q;
   logic                rd_pend_q;
   logic [31:0]         hold_q;
   logic                gnt;
   logic                accept;
   logic                addr_unused;

   assign addr_unused = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         if (INIT_EN) state_q <= ST_INIT;
         else         state_q <= ST_RUN;
         cnt_q       <= '0;
         init_done_q <= ~INIT_EN;
         rvalid_q    <= 1'b0;
         rd_pend_q   <= 1'b0;
         hold_q      <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         rvalid_q    <= accept;
         rd_pend_q   <= accept & ~bus.we_i;
         if (rd_pend_q) hold_q <= DO_i;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      gnt         = 1'b0;
      accept      = 1'b0;
      A_o         = bus.addr_i[ADDR_W+1:2];
      DI_o        = bus.wdata_i;
      WEB_o       = 4'hF;
      case (state_q)
         ST_INIT: begin
            A_o   = cnt_q;
            DI_o  = INIT_VALUE;
            WEB_o = 4'h0;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end
         end
         ST_RUN: begin
            gnt    = bus.req_i;
            accept = bus.req_i;
            if (accept && bus.we_i) WEB_o = ~bus.be_i;
         end
         default: state_d = ST_RUN;
      endcase
      // Keep the macro write-protected for the whole time reset is asserted.
      if (RST) begin
         WEB_o  = 4'hF;
         gnt    = 1'b0;
         accept = 1'b0;
      end
   end

   assign bus.gnt_o    = gnt;
   assign bus.rvalid_o = rvalid_q;
   assign bus.rdata_o  = rd_pend_q ? DO_i : hold_q;
   assign init_done_o  = init_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_bank_ctrl
// Description : Directed self-checking bench for sp_ram_bank_ctrl with an SRAM model.
// Revision    : 1.0
// ============================================================================
module tb_sp_ram_bank_ctrl;

   logic        CK;
   logic        RST;
   logic        init_done;
   logic [12:0] A;
   logic [31:0] DI;
   logic [3:0]  WEB;
   logic [31:0] DO;
   logic [31:0] mem [0:8191];

   int n_checks = 0;
   int n_fail   = 0;

   sp_ram_bank_ctrl_if bus_if ();

   sp_ram_bank_ctrl dut (
      .CK          (CK),
      .RST         (RST),
      .bus         (bus_if.slave),
      .init_done_o (init_done),
      .A_o         (A),
      .DI_o        (DI),
      .WEB_o       (WEB),
      .DO_i        (DO)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   // SRAM macro: byte writes, DO shows written word on writes, stored word on reads.
   always @(posedge CK) begin
      logic [31:0] w;
      w = mem[A];
      if (WEB != 4'hF) begin
         for (int b = 0; b < 4; b++)
            if (!WEB[b]) w[8*b +: 8] = DI[8*b +: 8];
         mem[A] <= w;
      end
      DO <= w;
   end

   task automatic drive(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus_if.req_i   = req;
      bus_if.we_i    = we;
      bus_if.be_i    = be;
      bus_if.addr_i  = addr;
      bus_if.wdata_i = wdata;
   endtask

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic test_reset();
      int bad;
      int first;
      RST = 1'b1;
      drive(1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
      repeat (2) @(posedge CK);
      @(negedge CK);
      n_checks++; if (bus_if.gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", bus_if.gnt_o); end
      n_checks++; if (WEB !== 4'hF) begin n_fail++; $display("FAIL reset_web: got %h expected f", WEB); end
      n_checks++; if (bus_if.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", bus_if.rvalid_o); end
      n_checks++; if (bus_if.rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus_if.rdata_o); end
      n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
      step();
      RST = 1'b0;
      bad = 0;
      first = -1;
      for (int k = 0; k < 8192; k++) begin
         @(negedge CK);
         if (A !== 13'(k) || WEB !== 4'h0 || DI !== 32'h0 || bus_if.gnt_o !== 1'b0 || init_done !== 1'b0) begin
            if (bad == 0) first = k;
            bad++;
         end
         step();
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sweep_pattern: got %0d bad cycles (first %0d) expected 0", bad, first); end
      @(negedge CK);
      n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL sweep_init_done: got %b expected 1", init_done); end
      n_checks++; if (bus_if.gnt_o !== 1'b1) begin n_fail++; $display("FAIL held_req_gnt: got %b expected 1", bus_if.gnt_o); end
      step();
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge CK);
      n_checks++; if (bus_if.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL held_req_rvalid: got %b expected 1", bus_if.rvalid_o); end
      n_checks++; if (bus_if.rdata_o !== 32'h0) begin n_fail++; $display("FAIL held_req_rdata: got %h expected 0", bus_if.rdata_o); end
      step();
   endtask

   task automatic test_write_read();
      drive(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
      @(negedge CK);
      n_checks++; if (bus_if.gnt_o !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b expected 1", bus_if.gnt_o); end
      n_checks++; if (A !== 13'd4) begin n_fail++; $display("FAIL wr_addr: got %0d expected 4", A); end
      n_checks++; if (WEB !== 4'h0) begin n_fail++; $display("FAIL wr_web: got %h expected 0", WEB); end
      n_checks++; if (DI !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_di: got %h expected deadbeef", DI); end
      step();
      drive(1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
      @(negedge CK);
      n_checks++; if (bus_if.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL wr_rvalid: got %b expected 1", bus_if.rvalid_o); end
      n_checks++; if (WEB !== 4'hF) begin n_fail++; $display("FAIL rd_web: got %h expected f", WEB); end
      step();
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge CK);
      n_checks++; if (bus_if.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %b expected 1", bus_if.rvalid_o); end
      n_checks++; if (bus_if.rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", bus_if.rdata_o); end
      step();
      @(negedge CK);
      n_checks++; if (bus_if.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid: got %b expected 0", bus_if.rvalid_o); end
      step();
   endtask

   task automatic test_byte_write();
      drive(1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
      step();
      drive(1'b1, 1'b1, 4'b0100, 32'h0000_0020, 32'h00AA_0000);
      @(negedge CK);
      n_checks++; if (WEB !== 4'b1011) begin n_fail++; $display("FAIL byte_web: got %b expected 1011", WEB); end
      step();
      drive(1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
      step();
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge CK);
      n_checks++; if (bus_if.rdata_o !== 32'h11AA_3344) begin n_fail++; $display("FAIL byte_rdata: got %h expected 11aa3344", bus_if.rdata_o); end
      step();
   endtask

   task automatic test_rdata_hold();
      drive(1'b1, 1'b1, 4'hF, 32'h0000_0014, 32'h5555_5555);
      step();
      drive(1'b1, 1'b1, 4'hF, 32'h0000_0018, 32'h6666_6666);
      step();
      drive(1'b1, 1'b0, 4'hF, 32'h0000_0014, 32'h0);
      step();
      drive(1'b1, 1'b1, 4'hF, 32'h0000_0018, 32'h7777_7777);
      @(negedge CK);
      n_checks++; if (bus_if.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL hold_rd_rvalid: got %b expected 1", bus_if.rvalid_o); end
      n_checks++; if (bus_if.rdata_o !== 32'h5555_5555) begin n_fail++; $display("FAIL hold_rd_data: got %h expected 55555555", bus_if.rdata_o); end
      step();
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CK);
         n_checks++;
         if (bus_if.rvalid_o !== (i == 0)) begin n_fail++; $display("FAIL hold_rvalid_%0d: got %b expected %b", i, bus_if.rvalid_o, (i == 0)); end
         n_checks++;
         if (bus_if.rdata_o !== 32'h5555_5555) begin n_fail++; $display("FAIL hold_data_%0d: got %h expected 55555555", i, bus_if.rdata_o); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 4'hF, 32'(i * 4), 32'(i + 1));
         @(negedge CK);
         n_checks++; if (bus_if.gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_gnt_%0d: got %b expected 1", i, bus_if.gnt_o); end
         step();
      end
      for (int i = 0; i < 5; i++) begin
         if (i < 4) drive(1'b1, 1'b0, 4'hF, 32'(i * 4), 32'h0);
         else       drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         @(negedge CK);
         if (i < 4) begin
            n_checks++; if (bus_if.gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_gnt_%0d: got %b expected 1", i, bus_if.gnt_o); end
         end
         n_checks++; if (bus_if.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid_%0d: got %b expected 1", i, bus_if.rvalid_o); end
         if (i > 0) begin
            n_checks++; if (bus_if.rdata_o !== 32'(i)) begin n_fail++; $display("FAIL b2b_rdata_%0d: got %h expected %h", i, bus_if.rdata_o, 32'(i)); end
         end
         step();
      end
      @(negedge CK);
      n_checks++; if (bus_if.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end_rvalid: got %b expected 0", bus_if.rvalid_o); end
      step();
   endtask

   task automatic test_reset_mid();
      int bad;
      int first;
      RST = 1'b1;
      #1;
      n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_init_done: got %b expected 0", init_done); end
      n_checks++; if (WEB !== 4'hF) begin n_fail++; $display("FAIL mid_rst_web: got %h expected f", WEB); end
      step();
      RST = 1'b0;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge CK);
         if (A !== 13'(k) || WEB !== 4'h0 || bus_if.rvalid_o !== 1'b0) bad++;
         step();
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL sweep100_pattern: got %0d bad cycles expected 0", bad); end
      @(negedge CK);
      n_checks++; if (A !== 13'd100) begin n_fail++; $display("FAIL sweep100_addr: got %0d expected 100", A); end
      RST = 1'b1;
      #1;
      n_checks++; if (WEB !== 4'hF) begin n_fail++; $display("FAIL sweep_rst_web: got %h expected f", WEB); end
      n_checks++; if (bus_if.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL sweep_rst_rvalid: got %b expected 0", bus_if.rvalid_o); end
      step();
      RST = 1'b0;
      bad = 0;
      first = -1;
      for (int k = 0; k < 8192; k++) begin
         @(negedge CK);
         if (A !== 13'(k) || WEB !== 4'h0 || init_done !== 1'b0 || bus_if.rvalid_o !== 1'b0) begin
            if (bad == 0) first = k;
            bad++;
         end
         step();
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL resweep_pattern: got %0d bad cycles (first %0d) expected 0", bad, first); end
      @(negedge CK);
      n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL resweep_init_done: got %b expected 1", init_done); end
      step();
      drive(1'b1, 1'b1, 4'hF, 32'h0000_0024, 32'hCAFE_0001);
      step();
      drive(1'b1, 1'b0, 4'hF, 32'h0000_0024, 32'h0);
      step();
      RST = 1'b1;
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1;
      n_checks++; if (bus_if.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL xfer_rst_rvalid: got %b expected 0", bus_if.rvalid_o); end
      n_checks++; if (bus_if.rdata_o !== 32'h0) begin n_fail++; $display("FAIL xfer_rst_rdata: got %h expected 0", bus_if.rdata_o); end
      n_checks++; if (WEB !== 4'hF) begin n_fail++; $display("FAIL xfer_rst_web: got %h expected f", WEB); end
      step();
      RST = 1'b0;
      bad = 0;
      first = -1;
      for (int k = 0; k < 8192; k++) begin
         @(negedge CK);
         if (A !== 13'(k) || WEB !== 4'h0 || bus_if.rvalid_o !== 1'b0) begin
            if (bad == 0) first = k;
            bad++;
         end
         step();
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL xfer_resweep: got %0d bad cycles (first %0d) expected 0", bad, first); end
      @(negedge CK);
      n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL xfer_init_done: got %b expected 1", init_done); end
      n_checks++; if (bus_if.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL xfer_stale_rvalid: got %b expected 0", bus_if.rvalid_o); end
      step();
   endtask

   initial begin
      RST = 1'b1;
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      test_reset();
      test_write_read();
      test_byte_write();
      test_rdata_hold();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
